// File: rtl/mux4_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4:1 mux select arbiter.
package mux4_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [SEL_W-1:0] s);
        return NUM_CH'(1) << s;
    endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational requester pick: round-robin after ptr, or lowest index when
// MUX4_FIXED_PRIO_EN is defined.
module mux4_rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  pick,
    output logic              any
);

`ifdef MUX4_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        any  = |req;
        // Descending scan so the lowest requesting index is the final winner.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) pick = SEL_W'(i);
        end
    end
`else
    logic [SEL_W-1:0] idx;

    always_comb begin
        pick = ptr;
        any  = |req;
        idx  = '0;
        // Scan ptr+4 (== ptr, lowest priority) down to ptr+1 so ptr+1 wins last.
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) pick = idx;
        end
    end
`endif

endmodule

// File: rtl/mux4_rr_sel_arbiter.sv
// Select generator for a 4:1 mux: round-robin grant with bounded bursts and a
// valid/ready qualified output. Optional MUX4_FIXED_PRIO_EN selects fixed priority.
module mux4_rr_sel_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              ready,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] gnt,
    output logic              valid,
    output logic              last
);

    arb_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              busy, accept, rel, any;
    logic [SEL_W-1:0]  pick, pick_ptr;

    assign busy   = (state_q == ST_GRANT);
    assign valid  = busy & req[sel_q];
    assign accept = valid & ready;
    assign last   = valid & (cnt_q == CNT_W'(BURST_LEN - 1));
    assign rel    = busy & ((accept & last) | ~req[sel_q]);

    // On release ptr becomes sel_q at the edge; feed that value forward so the
    // back-to-back re-grant already sees the updated pointer.
    assign pick_ptr = busy ? sel_q : ptr_q;

    mux4_rr_pick u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    sel_d   = pick;
                    gnt_d   = onehot4(pick);
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    ptr_d = sel_q;
                    if (any) begin
                        sel_d = pick;
                        gnt_d = onehot4(pick);
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel = sel_q;
    assign gnt = gnt_q;

endmodule

// File: tb/tb_mux4_rr_sel_arbiter.sv
// Randomized bench for mux4_rr_sel_arbiter against a behavioural arbitration model.
module tb_mux4_rr_sel_arbiter;

    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic       last;

    int checks = 0;
    int errors = 0;

    // Model state: owner channel (-1 when idle), beats taken, rotation pointer.
    int owner;
    int beats;
    int ptr;
    int shown_sel;

    always #5 clk = ~clk;

    mux4_rr_sel_arbiter #(.BURST_LEN(BL), .CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid),
        .last  (last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_m(input logic [3:0] r, input int p);
`ifdef MUX4_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
        for (int i = 1; i <= 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
`endif
        return -1;
    endfunction

    function automatic bit m_valid();
        return owner >= 0 && req[owner] == 1'b1;
    endfunction

    task automatic model_reset();
        owner = -1; beats = 0; ptr = 3; shown_sel = 0;
    endtask

    task automatic model_step();
        bit v, acc, rel;
        if (rst) begin
            model_reset();
            return;
        end
        if (owner < 0) begin
            if (req != 0) begin
                owner = pick_m(req, ptr); beats = 0; shown_sel = owner;
            end
            return;
        end
        v   = m_valid();
        acc = v && ready;
        rel = (acc && beats == BL - 1) || !req[owner];
        if (rel) begin
            ptr = owner;
            if (req != 0) begin
                owner = pick_m(req, ptr); beats = 0; shown_sel = owner;
            end else begin
                owner = -1;
            end
        end else if (acc) begin
            beats++;
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = m_valid();
        chk("sel",   32'(sel),   32'(shown_sel));
        chk("gnt",   32'(gnt),   owner >= 0 ? 32'(1 << owner) : 32'd0);
        chk("valid", 32'(valid), 32'(v));
        chk("last",  32'(last),  32'(v && beats == BL - 1));
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",   32'(sel),   32'd0);
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_last",  32'(last),  32'd0);

        for (int ph = 0; ph < 5; ph++) begin
            for (int c = 0; c < 300; c++) begin
                rst = 1'b0;
                case (ph)
                    0: begin req = (c < 20) ? 4'b0100 : 4'b1111; ready = 1'b1; end
                    1: begin
                        if ($urandom_range(7) == 0) req = 4'($urandom);
                        ready = ($urandom_range(3) != 0);
                    end
                    2: begin req = 4'($urandom); ready = $urandom_range(1) == 1; end
                    3: begin
                        if ($urandom_range(5) == 0) req = 4'($urandom);
                        ready = ($urandom_range(3) != 0);
                        rst   = ($urandom_range(39) == 0);
                    end
                    default: begin
                        // Sparse requests exercise idle entry and withdrawal.
                        req   = ($urandom_range(2) == 0) ? 4'(1 << $urandom_range(3)) : req;
                        if ($urandom_range(9) == 0) req = 4'b0;
                        ready = ($urandom_range(4) != 0);
                    end
                endcase
                @(negedge clk);
                check_outputs();
                @(posedge clk);
                model_step();
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
